ad1_multi_controller: RTL and testbench

- Parametrised successor to the two-channel PmodAD1 controller.
- Drives a shared chip-select (CS) and serial clock (SCLKO) to N_CH serial ADCs of the AD7476A type: 4 leading zeros, then 12 data bits, MSB first.
- Deserialises all channels in parallel.
- Adds a programmable SCLK divider, single-shot and continuous modes, a valid strobe, a busy flag and leading-zero error detection.
- Sits between the board-level ADC pins and the sensor-processing logic, e.g. drum pad hit detection.

---
 rtl/ad1_multi_controller.sv | 163 ++++++++++++++++
 tb/tb_ad1_multi_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ad1_multi_controller.sv
// Shared-CS/SCLKO controller for N_CH AD7476A-style serial ADCs.
// Channels are deserialised in parallel; results publish atomically with a VALID pulse.
module ad1_lane #(
  parameter int DATA_W    = 12,
  parameter int FRAME_LEN = 16
) (
  input  logic              SCLKI,
  input  logic              RST,
  input  logic              cap_i,
  input  logic              din_i,
  output logic [DATA_W-1:0] data_o,
  output logic              lz_o
);
  logic [FRAME_LEN-1:0] sh_q;

  always_ff @(posedge SCLKI or posedge RST)
    if (RST)        sh_q <= '0;
    else if (cap_i) sh_q <= {sh_q[FRAME_LEN-2:0], din_i};

  assign data_o = sh_q[DATA_W-1:0];

  generate
    if (FRAME_LEN > DATA_W) begin : g_lz
      assign lz_o = |sh_q[FRAME_LEN-1:DATA_W];
    end else begin : g_nolz
      assign lz_o = 1'b0;
    end
  endgenerate
endmodule

module ad1_multi_controller #(
  parameter int N_CH      = 2,
  parameter int DATA_W    = 12,
  parameter int FRAME_LEN = 16,
  parameter int CLK_DIV   = 1,
  parameter int QUIET     = 2
) (
  input  logic                   SCLKI,
  input  logic                   RST,
  input  logic                   START,
  input  logic                   CONT,
  input  logic [N_CH-1:0]        aDATA,
  output logic                   CS,
  output logic                   SCLKO,
  output logic [N_CH*DATA_W-1:0] DATA,
  output logic                   VALID,
  output logic                   LZ_ERR,
  output logic                   BUSY
);
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int Q_W    = (QUIET > 1) ? $clog2(QUIET) : 1;
  localparam int Q_LAST = (QUIET > 1) ? QUIET - 2 : 0;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_DONE, S_QUIET} state_t;

  state_t                        state_q;
  logic                          cs_q, sclk_q, valid_q, lz_q, busy_q;
  logic [DIV_W-1:0]              div_q;
  logic [BIT_W-1:0]              bit_q;
  logic [Q_W-1:0]                q_q;
  logic [N_CH-1:0][DATA_W-1:0]   data_q, lane_data;
  logic [N_CH-1:0]               lane_lz;
  logic                          div_end, cap;

  assign div_end = (div_q == DIV_W'(CLK_DIV - 1));
  // Capture on the same edge that drives SCLKO 0->1, i.e. data settled through the low phase.
  assign cap     = (state_q == S_SHIFT) && !sclk_q && div_end;

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_lane
      ad1_lane #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN)) u_lane (
        .SCLKI (SCLKI),
        .RST   (RST),
        .cap_i (cap),
        .din_i (aDATA[g]),
        .data_o(lane_data[g]),
        .lz_o  (lane_lz[g])
      );
    end
  endgenerate

  always_ff @(posedge SCLKI or posedge RST)
    if (RST) begin
      state_q <= S_IDLE;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b1;
      valid_q <= 1'b0;
      lz_q    <= 1'b0;
      busy_q  <= 1'b0;
      div_q   <= '0;
      bit_q   <= '0;
      q_q     <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      lz_q    <= 1'b0;
      case (state_q)
        S_IDLE:
          if (START || CONT) begin
            state_q <= S_SETUP;
            cs_q    <= 1'b0;
            busy_q  <= 1'b1;
            div_q   <= '0;
          end
        S_SETUP:
          if (div_end) begin
            state_q <= S_SHIFT;
            sclk_q  <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
          end else div_q <= div_q + 1'b1;
        S_SHIFT:
          if (!div_end) div_q <= div_q + 1'b1;
          else begin
            div_q <= '0;
            if (!sclk_q) sclk_q <= 1'b1;
            else if (bit_q == BIT_W'(FRAME_LEN - 1)) begin
              state_q <= S_DONE;
              cs_q    <= 1'b1;
              valid_q <= 1'b1;
              lz_q    <= |lane_lz;
              data_q  <= lane_data;
            end else begin
              sclk_q <= 1'b0;
              bit_q  <= bit_q + 1'b1;
            end
          end
        S_DONE: begin
          q_q <= '0;
          if (QUIET > 1) state_q <= S_QUIET;
          else if (CONT) begin
            state_q <= S_SETUP;
            cs_q    <= 1'b0;
            div_q   <= '0;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_QUIET:
          if (q_q == Q_W'(Q_LAST)) begin
            if (CONT) begin
              state_q <= S_SETUP;
              cs_q    <= 1'b0;
              div_q   <= '0;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else q_q <= q_q + 1'b1;
        default: state_q <= S_IDLE;
      endcase
    end

  assign CS     = cs_q;
  assign SCLKO  = sclk_q;
  assign DATA   = data_q;
  assign VALID  = valid_q;
  assign LZ_ERR = lz_q;
  assign BUSY   = busy_q;
endmodule

// File: tb/tb_ad1_multi_controller.sv
// Bench for ad1_multi_controller: default 2-channel instance and a 4-channel CLK_DIV=3 instance,
// each fed by an ADC model that shifts a 16-bit word MSB first on SCLKO falling edges.
module tb_ad1_multi_controller;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, cyc = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic close_run(inout int run, inout int mn, inout int mx);
    if (run > 0) begin
      if (run < mn) mn = run;
      if (run > mx) mx = run;
      run = 0;
    end
  endtask

  // ---------------- instance A: defaults ----------------
  logic        a_rst, a_start, a_cont, a_cs, a_sclko, a_valid, a_lz, a_busy;
  logic [1:0]  a_din;
  logic [23:0] a_data;
  logic [1:0][15:0] a_stim_q[$];
  logic [24:0]      a_exp_q[$];
  logic [1:0][15:0] a_cur;
  logic [24:0]      ea;
  int a_idx, a_vcnt = 0, a_cslow = 0, a_rise = 0, a_gap = 0, a_last_gap = 0;
  int a_vt[$];

  ad1_multi_controller dut_a (
    .SCLKI(clk), .RST(a_rst), .START(a_start), .CONT(a_cont), .aDATA(a_din),
    .CS(a_cs), .SCLKO(a_sclko), .DATA(a_data), .VALID(a_valid), .LZ_ERR(a_lz), .BUSY(a_busy)
  );

  always @(negedge a_cs) begin
    a_cur = (a_stim_q.size() > 0) ? a_stim_q.pop_front() : '0;
    a_idx = 15;
  end
  always @(negedge a_sclko)
    if (!a_cs && a_idx >= 0) begin
      for (int c = 0; c < 2; c++) a_din[c] = a_cur[c][a_idx];
      a_idx--;
    end
  always @(posedge a_sclko) a_rise++;

  always @(negedge clk) begin
    cyc++;
    if (a_valid) begin
      a_vcnt++;
      a_vt.push_back(cyc);
      if (a_exp_q.size() == 0) check("A unexpected VALID", a_valid, 0);
      else begin
        ea = a_exp_q.pop_front();
        check("A DATA", a_data, ea[23:0]);
        check("A LZ_ERR", a_lz, ea[24]);
      end
    end else check("A LZ_ERR outside VALID", a_lz, 0);
    if (!a_cs) a_cslow++;
    if (!a_busy) a_gap = 0;
    else if (a_cs) a_gap++;
    else if (a_gap != 0) begin a_last_gap = a_gap; a_gap = 0; end
  end

  task automatic a_wait_idle();
    int n = 0;
    while (a_busy && n < 400) begin @(negedge clk); n++; end
    check("A BUSY back to 0", a_busy, 0);
  endtask

  task automatic a_frame(input logic [15:0] w0, input logic [15:0] w1,
                         input logic [23:0] d, input logic lz);
    int v0;
    a_stim_q.push_back({w1, w0});
    a_exp_q.push_back({lz, d});
    v0 = a_vcnt; a_cslow = 0; a_rise = 0;
    a_start = 1'b1; @(negedge clk); a_start = 1'b0; @(negedge clk);
    a_wait_idle();
    check("A CS low cycles", a_cslow, 33);
    check("A SCLKO rises", a_rise, 16);
    check("A VALID per frame", a_vcnt - v0, 1);
    check("A scoreboard drained", a_exp_q.size(), 0);
  endtask

  // ---------------- instance B: 4 channels, CLK_DIV=3 ----------------
  logic        b_rst, b_start, b_cont, b_cs, b_sclko, b_valid, b_lz, b_busy;
  logic [3:0]  b_din;
  logic [47:0] b_data;
  logic [3:0][15:0] b_stim_q[$];
  logic [48:0]      b_exp_q[$];
  logic [3:0][15:0] b_cur;
  logic [48:0]      eb;
  int b_idx, b_vcnt = 0, b_cslow = 0, b_rise = 0, b_lotot = 0;
  int b_lrun = 0, b_lmin = 1000, b_lmax = 0, b_hrun = 0, b_hmin = 1000, b_hmax = 0;

  ad1_multi_controller #(.N_CH(4), .CLK_DIV(3)) dut_b (
    .SCLKI(clk), .RST(b_rst), .START(b_start), .CONT(b_cont), .aDATA(b_din),
    .CS(b_cs), .SCLKO(b_sclko), .DATA(b_data), .VALID(b_valid), .LZ_ERR(b_lz), .BUSY(b_busy)
  );

  always @(negedge b_cs) begin
    b_cur = (b_stim_q.size() > 0) ? b_stim_q.pop_front() : '0;
    b_idx = 15;
  end
  always @(negedge b_sclko)
    if (!b_cs && b_idx >= 0) begin
      for (int c = 0; c < 4; c++) b_din[c] = b_cur[c][b_idx];
      b_idx--;
    end
  always @(posedge b_sclko) b_rise++;

  always @(negedge clk) begin
    if (b_valid) begin
      b_vcnt++;
      if (b_exp_q.size() == 0) check("B unexpected VALID", b_valid, 0);
      else begin
        eb = b_exp_q.pop_front();
        check("B DATA", b_data, eb[47:0]);
        check("B LZ_ERR", b_lz, eb[48]);
      end
    end
    if (!b_cs) begin
      b_cslow++;
      if (b_sclko) begin b_hrun++; close_run(b_lrun, b_lmin, b_lmax); end
      else begin b_lrun++; b_lotot++; close_run(b_hrun, b_hmin, b_hmax); end
    end else begin
      close_run(b_lrun, b_lmin, b_lmax);
      close_run(b_hrun, b_hmin, b_hmax);
    end
  end

  task automatic b_frame(input logic [3:0][15:0] w, input logic [47:0] d, input logic lz);
    int v0, n;
    b_stim_q.push_back(w);
    b_exp_q.push_back({lz, d});
    v0 = b_vcnt; b_cslow = 0; b_rise = 0; b_lotot = 0;
    b_lmin = 1000; b_lmax = 0; b_hmin = 1000; b_hmax = 0;
    b_start = 1'b1; @(negedge clk); b_start = 1'b0; @(negedge clk);
    n = 0;
    while (b_busy && n < 600) begin @(negedge clk); n++; end
    check("B BUSY back to 0", b_busy, 0);
    check("B CS low cycles", b_cslow, 99);
    check("B SCLKO rises", b_rise, 16);
    check("B SCLKO low cycles", b_lotot, 48);
    check("B low phase min", b_lmin, 3);
    check("B low phase max", b_lmax, 3);
    check("B high phase min", b_hmin, 3);
    check("B high phase max", b_hmax, 3);
    check("B VALID per frame", b_vcnt - v0, 1);
  endtask

  typedef struct {
    logic [15:0] w0, w1;
    logic [23:0] d;
    logic        lz;
  } vec_t;
  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, n;
    a_rst = 1'b1; a_start = 1'b0; a_cont = 1'b0; a_din = '0;
    b_rst = 1'b1; b_start = 1'b0; b_cont = 1'b0; b_din = '0;
    vecs[0] = '{16'h0A5C, 16'h0FFF, 24'hFFFA5C, 1'b0};
    vecs[1] = '{16'h0A5C, 16'h8123, 24'h123A5C, 1'b1};
    vecs[2] = '{16'h0000, 16'h0000, 24'h000000, 1'b0};
    vecs[3] = '{16'h1FFF, 16'h0001, 24'h001FFF, 1'b1};
    vecs[4] = '{16'h0ABC, 16'h0123, 24'h123ABC, 1'b0};
    vecs[5] = '{16'h0800, 16'h4000, 24'h000800, 1'b1};

    repeat (3) @(negedge clk);
    check("A reset CS", a_cs, 1);       check("A reset SCLKO", a_sclko, 1);
    check("A reset DATA", a_data, 0);   check("A reset VALID", a_valid, 0);
    check("A reset LZ_ERR", a_lz, 0);   check("A reset BUSY", a_busy, 0);
    check("B reset CS", b_cs, 1);       check("B reset DATA", b_data, 0);
    a_rst = 1'b0; b_rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) a_frame(vecs[i].w0, vecs[i].w1, vecs[i].d, vecs[i].lz);

    // continuous: three frames back to back, CONT dropped during the third
    a_vt.delete(); a_last_gap = 0; v0 = a_vcnt;
    for (int k = 1; k <= 3; k++) begin
      a_stim_q.push_back({16'h0000, 16'(k)});
      a_exp_q.push_back({1'b0, 24'(k)});
    end
    a_cont = 1'b1;
    n = 0;
    while (a_vcnt < v0 + 2 && n < 300) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    a_cont = 1'b0;
    a_wait_idle();
    check("A cont VALID count", a_vt.size(), 3);
    if (a_vt.size() >= 3) begin
      check("A cont VALID spacing 1-2", a_vt[1] - a_vt[0], 35);
      check("A cont VALID spacing 2-3", a_vt[2] - a_vt[1], 35);
    end
    check("A cont CS high gap", a_last_gap, 2);

    // reset in the middle of SHIFT
    a_stim_q.push_back({16'h0123, 16'h0ABC});
    a_exp_q.push_back({1'b0, 24'h123ABC});
    v0 = a_vcnt; a_rise = 0;
    a_start = 1'b1; @(negedge clk); a_start = 1'b0;
    n = 0;
    while (a_rise < 7 && n < 200) begin @(negedge clk); n++; end
    check("A reached SHIFT bit 7", a_rise, 7);
    #1 a_rst = 1'b1;
    #1;
    check("A abort CS", a_cs, 1);       check("A abort SCLKO", a_sclko, 1);
    check("A abort DATA", a_data, 0);   check("A abort VALID", a_valid, 0);
    check("A abort BUSY", a_busy, 0);
    a_exp_q.delete(); a_stim_q.delete();
    repeat (3) @(negedge clk);
    a_rst = 1'b0;
    repeat (60) @(negedge clk);
    check("A no VALID after abort", a_vcnt - v0, 0);
    a_frame(16'h0F0F, 16'h00F0, 24'h0F0F0F, 1'b0);

    // START while busy and during QUIET is dropped
    a_stim_q.push_back({16'h0654, 16'h0321});
    a_exp_q.push_back({1'b0, 24'h654321});
    v0 = a_vcnt;
    a_start = 1'b1; @(negedge clk); a_start = 1'b0;
    repeat (10) @(negedge clk);
    a_start = 1'b1; @(negedge clk); a_start = 1'b0;
    n = 0;
    while (!a_valid && n < 100) begin @(negedge clk); n++; end
    check("A VALID seen before QUIET", a_valid, 1);
    @(negedge clk);
    a_start = 1'b1; @(negedge clk); a_start = 1'b0;
    repeat (60) @(negedge clk);
    check("A one VALID per accepted START", a_vcnt - v0, 1);
    check("A idle after ignored STARTs", a_busy, 0);

    b_frame({16'h0ABC, 16'h0789, 16'h0456, 16'h0123}, 48'hABC789456123, 1'b0);
    b_frame({16'h0555, 16'h2000, 16'h0000, 16'h0FFF}, 48'h555000000FFF, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
